// File: rtl/mod_ctrl_pkg.sv
// Shared types and defaults for the sweep controller and its MOD-N counter.
package mod_ctrl_pkg;

  localparam int unsigned DEF_MOD = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/bidir_mod_counter.sv
// Bidirectional MOD-N counter with synchronous load; load has priority over en.
module bidir_mod_counter
  import mod_ctrl_pkg::*;
#(
  parameter int unsigned MOD = DEF_MOD,
  parameter int unsigned CW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          up_down,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MOD - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up_down) begin
        count <= (count == CNT_MAX) ? '0 : count + CW'(1);
      end else begin
        count <= (count == '0) ? CNT_MAX : count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter_sweep_ctrl.sv
// Start/busy/done sequencer sweeping a MOD-N counter between latched limits
// for a programmed number of legs.
module mod_counter_sweep_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter int unsigned MOD     = DEF_MOD,
  parameter int unsigned CW      = $clog2(MOD),
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CW-1:0]      lo_lim,
  input  logic [CW-1:0]      hi_lim,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic               dir_init,
  output logic [CW-1:0]      count,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MOD - 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        lo_q, hi_q;
  logic [SWEEP_W-1:0]   num_q;
  logic                 cfg_ok, leg_end, last_leg;
  logic                 cnt_en, cnt_load, cnt_dir;
  logic [CW-1:0]        cnt_val;
  logic                 done_nxt, abort_nxt, err_nxt;
  logic                 latch, sweep_clr, sweep_inc;

  assign cfg_ok   = (lo_lim < hi_lim) && (hi_lim <= CNT_MAX);
  assign leg_end  = ((state == RUN_UP) && (count == hi_q)) ||
                    ((state == RUN_DOWN) && (count == lo_q));
  assign last_leg = ((sweep_cnt + SWEEP_W'(1)) == num_q);
  assign busy     = (state != IDLE);
  assign cnt_dir  = (state == RUN_UP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      num_q     <= '0;
      sweep_cnt <= '0;
      up_down   <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      aborted <= abort_nxt;
      cfg_err <= err_nxt;
      if (latch) begin
        lo_q  <= lo_lim;
        hi_q  <= hi_lim;
        num_q <= num_sweeps;
      end
      if (sweep_clr) begin
        sweep_cnt <= '0;
      end else if (sweep_inc) begin
        sweep_cnt <= sweep_cnt + SWEEP_W'(1);
      end
      // Direction tracks the state entered; IDLE keeps the last leg's direction.
      if (state_nxt != IDLE) begin
        up_down <= (state_nxt == RUN_UP);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && cfg_ok && (num_sweeps != '0)) begin
          state_nxt = dir_init ? RUN_UP : RUN_DOWN;
        end
      end
      RUN_UP, RUN_DOWN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (leg_end) begin
          if (last_leg) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = (state == RUN_UP) ? RUN_DOWN : RUN_UP;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;
    latch     = 1'b0;
    sweep_clr = 1'b0;
    sweep_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!cfg_ok) begin
            err_nxt = 1'b1;
          end else if (num_sweeps == '0) begin
            done_nxt = 1'b1;
          end else begin
            latch     = 1'b1;
            sweep_clr = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = dir_init ? lo_lim : hi_lim;
          end
        end
      end
      RUN_UP, RUN_DOWN: begin
        if (stop) begin
          abort_nxt = 1'b1;
        end else if (leg_end) begin
          sweep_inc = 1'b1;
          // Reverse by loading the first value of the next leg so the limit is not repeated.
          if (last_leg) begin
            done_nxt = 1'b1;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = (state == RUN_UP) ? hi_q - CW'(1) : lo_q + CW'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  bidir_mod_counter #(
    .MOD (MOD),
    .CW  (CW)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_val),
    .up_down  (cnt_dir),
    .count    (count)
  );

endmodule

// File: tb/tb_mod_counter_sweep_ctrl.sv
// Table-driven bench for mod_counter_sweep_ctrl with a per-cycle expected-output queue.
module tb_mod_counter_sweep_ctrl;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] n;
    logic       dir;
    int         stop_at;
    bit         restart;
  } vec_t;

  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       up_down;
    logic       done;
    logic       aborted;
    logic       cfg_err;
    logic [7:0] sweep;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, start, stop, dir_init;
  logic [3:0] lo_lim, hi_lim, count;
  logic [7:0] num_sweeps, sweep_cnt;
  logic       up_down, busy, done, aborted, cfg_err;

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  logic [3:0] m_count;
  logic       m_up;
  logic [7:0] m_sweep;
  vec_t vecs[11];

  always #5 clk = ~clk;

  mod_counter_sweep_ctrl #(
    .MOD     (10),
    .SWEEP_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .lo_lim     (lo_lim),
    .hi_lim     (hi_lim),
    .num_sweeps (num_sweeps),
    .dir_init   (dir_init),
    .count      (count),
    .up_down    (up_down),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .cfg_err    (cfg_err),
    .sweep_cnt  (sweep_cnt)
  );

  function automatic obs_t sample();
    return {count, busy, up_down, done, aborted, cfg_err, sweep_cnt};
  endfunction

  function automatic obs_t mk(logic [3:0] c, logic b, logic u, logic d, logic a, logic e,
                              logic [7:0] s);
    return {c, b, u, d, a, e, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expected observation after each clock, starting with the edge that samples start.
  task automatic gen(input vec_t v);
    logic [3:0] c;
    logic       up;
    logic [7:0] sw;
    int         k;
    bit         fin;
    if (!(v.lo < v.hi && v.hi <= 4'd9)) begin
      exp_q.push_back(mk(m_count, 1'b0, m_up, 1'b0, 1'b0, 1'b1, m_sweep));
      exp_q.push_back(mk(m_count, 1'b0, m_up, 1'b0, 1'b0, 1'b0, m_sweep));
    end else if (v.n == 8'd0) begin
      exp_q.push_back(mk(m_count, 1'b0, m_up, 1'b1, 1'b0, 1'b0, m_sweep));
      exp_q.push_back(mk(m_count, 1'b0, m_up, 1'b0, 1'b0, 1'b0, m_sweep));
    end else begin
      c   = v.dir ? v.lo : v.hi;
      up  = v.dir;
      sw  = 8'd0;
      k   = 0;
      fin = 1'b0;
      exp_q.push_back(mk(c, 1'b1, up, 1'b0, 1'b0, 1'b0, sw));
      while (!fin) begin
        if (k == v.stop_at) begin
          exp_q.push_back(mk(c, 1'b0, up, 1'b0, 1'b1, 1'b0, sw));
          fin = 1'b1;
        end else if (up && c < v.hi) begin
          c = c + 4'd1;
          exp_q.push_back(mk(c, 1'b1, up, 1'b0, 1'b0, 1'b0, sw));
        end else if (!up && c > v.lo) begin
          c = c - 4'd1;
          exp_q.push_back(mk(c, 1'b1, up, 1'b0, 1'b0, 1'b0, sw));
        end else begin
          sw = sw + 8'd1;
          if (sw == v.n) begin
            exp_q.push_back(mk(c, 1'b0, up, 1'b1, 1'b0, 1'b0, sw));
            fin = 1'b1;
          end else begin
            up = !up;
            c  = up ? v.lo + 4'd1 : v.hi - 4'd1;
            exp_q.push_back(mk(c, 1'b1, up, 1'b0, 1'b0, 1'b0, sw));
          end
        end
        k++;
      end
      exp_q.push_back(mk(c, 1'b0, up, 1'b0, 1'b0, 1'b0, sw));
      m_count = c;
      m_up    = up;
      m_sweep = sw;
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int   idx;
    int   done_idx;
    obs_t got, exp;
    idx      = 0;
    done_idx = -1;
    gen(v);
    @(negedge clk);
    start      = 1'b1;
    lo_lim     = v.lo;
    hi_lim     = v.hi;
    num_sweeps = v.n;
    dir_init   = v.dir;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = sample();
      exp = exp_q.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d cycle%0d: got count=%0d busy=%0b up=%0b done=%0b abort=%0b err=%0b sweep=%0d, expected count=%0d busy=%0b up=%0b done=%0b abort=%0b err=%0b sweep=%0d",
                 vi, idx, got.count, got.busy, got.up_down, got.done, got.aborted,
                 got.cfg_err, got.sweep, exp.count, exp.busy, exp.up_down, exp.done,
                 exp.aborted, exp.cfg_err, exp.sweep);
      end
      if (got.done === 1'b1 && done_idx < 0) done_idx = idx;
      start = 1'b0;
      stop  = (idx == v.stop_at);
      if (v.restart && idx == 1) begin
        start      = 1'b1;
        lo_lim     = 4'd0;
        hi_lim     = 4'd9;
        num_sweeps = 8'd0;
        dir_init   = ~v.dir;
      end
      idx++;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (v.lo < v.hi && v.hi <= 4'd9 && v.n != 8'd0 && v.stop_at < 0) begin
      chk($sformatf("vec%0d done_latency", vi), done_idx, 1 + int'(v.n) * (int'(v.hi) - int'(v.lo)));
    end
  endtask

  initial begin
    vecs[0]  = '{lo: 4'd2, hi: 4'd5,  n: 8'd2, dir: 1'b1, stop_at: -1, restart: 1'b0};
    vecs[1]  = '{lo: 4'd0, hi: 4'd9,  n: 8'd1, dir: 1'b0, stop_at: -1, restart: 1'b0};
    vecs[2]  = '{lo: 4'd6, hi: 4'd6,  n: 8'd3, dir: 1'b1, stop_at: -1, restart: 1'b0};
    vecs[3]  = '{lo: 4'd3, hi: 4'd12, n: 8'd3, dir: 1'b1, stop_at: -1, restart: 1'b0};
    vecs[4]  = '{lo: 4'd5, hi: 4'd3,  n: 8'd1, dir: 1'b0, stop_at: -1, restart: 1'b0};
    vecs[5]  = '{lo: 4'd1, hi: 4'd3,  n: 8'd0, dir: 1'b1, stop_at: -1, restart: 1'b0};
    vecs[6]  = '{lo: 4'd1, hi: 4'd4,  n: 8'd5, dir: 1'b1, stop_at: 3,  restart: 1'b0};
    vecs[7]  = '{lo: 4'd2, hi: 4'd5,  n: 8'd1, dir: 1'b1, stop_at: -1, restart: 1'b1};
    vecs[8]  = '{lo: 4'd0, hi: 4'd9,  n: 8'd3, dir: 1'b1, stop_at: -1, restart: 1'b0};
    vecs[9]  = '{lo: 4'd7, hi: 4'd8,  n: 8'd4, dir: 1'b0, stop_at: -1, restart: 1'b0};
    vecs[10] = '{lo: 4'd3, hi: 4'd7,  n: 8'd2, dir: 1'b0, stop_at: -1, restart: 1'b0};

    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    lo_lim     = '0;
    hi_lim     = '0;
    num_sweeps = '0;
    dir_init   = 1'b0;
    m_count    = '0;
    m_up       = 1'b0;
    m_sweep    = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(sample()), 32'(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // stop while idle must not produce a pulse or disturb the count
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_aborted", aborted, 0);
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_count", count, m_count);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; lo_lim = 4'd2; hi_lim = 4'd5; num_sweeps = 8'd2; dir_init = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_outputs", 32'(sample()), 32'(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
    @(negedge clk);
    chk("post_reset_quiet", 32'(sample()), 32'(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)));
    m_count = '0;
    m_up    = 1'b0;
    m_sweep = '0;
    run_vec(vecs[10], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
